m_store_buffer: RTL and testbench

- Posted-write store buffer placed directly upstream of the data memory stage. It is the only master of the memory port.
- Accepts committed stores from the M-stage pipeline register and queues them in a small FIFO. Drains one store per cycle into the byte-addressed data memory.
- Loads are passed straight through to the memory port. A load that overlaps a queued store is stalled until that store has drained, which keeps load data coherent.

---
 rtl/m_store_buffer_pkg.sv | 22 ++
 rtl/m_store_buffer_sb_fifo.sv | 59 +++++
 rtl/m_store_buffer.sv | 87 ++++++++
 tb/tb_m_store_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_store_buffer_pkg.sv
// rtl/m_store_buffer_pkg.sv - shared memory-mode codes, buffer depth and entry type for the store buffer
package m_store_buffer_pkg;

    localparam logic [1:0] MEM_WORD = 2'd0;
    localparam logic [1:0] MEM_BYTE = 2'd1;
    localparam logic [1:0] MEM_HALF = 2'd2;

    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } sb_entry_t;

    // Word-granular overlap test; deliberately ignores size and byte offset.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/m_store_buffer_sb_fifo.sv
// rtl/m_store_buffer_sb_fifo.sv - circular store-entry FIFO with an occupancy-masked address view
module sb_fifo
    import m_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head,
    output logic [31:0]      addrs [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addrs[i] = mem[i].addr;
            off      = PTR_W'(i) - rd_ptr;
            valid[i] = {1'b0, off} < count;
        end
    end

endmodule

// File: rtl/m_store_buffer.sv
// rtl/m_store_buffer.sv - posted-write store buffer owning the data-memory port, with load hazard stall and flush
module m_store_buffer
    import m_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [1:0]       st_mode,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [31:0]      st_pc,
    input  logic             ld_valid,
    input  logic [1:0]       ld_mode,
    input  logic [31:0]      ld_addr,
    output logic             ld_stall,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             mem_write,
    output logic             mem_read,
    output logic [31:0]      mem_mode,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    output logic [31:0]      mem_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    sb_entry_t        head;
    sb_entry_t        push_entry;
    logic [31:0]      addrs [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             push;
    logic             hit;
    logic             load_phase;
    logic             drain;

    assign push_entry = '{mode: st_mode, addr: st_addr, data: st_data, pc: st_pc};

    // No full-bypass: a full buffer refuses stores even on a draining cycle.
    assign st_ready = count < FULL;
    assign push     = st_valid & st_ready;

    sb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (head),
        .addrs      (addrs),
        .valid      (valid),
        .count      (count)
    );

    // Only already-queued entries are compared; a same-cycle push is younger than the load.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && same_word(addrs[i], ld_addr)) hit = 1'b1;
        end
        hit = hit & ld_valid;
    end

    assign load_phase = ld_valid & ~hit & ~flush_req;
    assign drain      = (count != '0) & ~load_phase;

    assign ld_stall   = hit | (flush_req & ld_valid);
    assign flush_done = flush_req & (count == '0);

    always_comb begin
        mem_read  = load_phase;
        mem_write = drain;
        mem_addr  = load_phase ? ld_addr : head.addr;
        mem_mode  = {30'd0, (load_phase ? ld_mode : head.mode)};
        mem_data  = head.data;
        mem_pc    = head.pc;
    end

endmodule

// File: tb/tb_m_store_buffer.sv
// tb/tb_m_store_buffer.sv - randomized and directed self-checking bench for m_store_buffer
module tb_m_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready;
    logic [1:0]  st_mode;
    logic [31:0] st_addr, st_data, st_pc;
    logic        ld_valid;
    logic [1:0]  ld_mode;
    logic [31:0] ld_addr;
    logic        ld_stall, flush_req, flush_done;
    logic        mem_write, mem_read;
    logic [31:0] mem_mode, mem_addr, mem_data, mem_pc;
    logic [2:0]  count;

    m_store_buffer dut (
        .clk (clk), .reset (reset),
        .st_valid (st_valid), .st_ready (st_ready), .st_mode (st_mode),
        .st_addr (st_addr), .st_data (st_data), .st_pc (st_pc),
        .ld_valid (ld_valid), .ld_mode (ld_mode), .ld_addr (ld_addr),
        .ld_stall (ld_stall), .flush_req (flush_req), .flush_done (flush_done),
        .mem_write (mem_write), .mem_read (mem_read), .mem_mode (mem_mode),
        .mem_addr (mem_addr), .mem_data (mem_data), .mem_pc (mem_pc),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] wlog[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Reference: the port goes to a non-conflicting load unless flushing, otherwise the oldest store drains.
    always @(negedge clk) begin : model
        int   n;
        bit   hit, ld_go, st_go;
        ent_t e;
        if (!reset) begin
            q.delete();
            chk("rst_count", 32'(count), 0);
            chk("rst_st_ready", 32'(st_ready), 1);
            chk("rst_ld_stall", 32'(ld_stall), 0);
            chk("rst_mem_write", 32'(mem_write), 0);
            chk("rst_mem_read", 32'(mem_read), 0);
            chk("rst_flush_done", 32'(flush_done), 0);
        end else begin
            n = q.size();
            hit = 1'b0;
            foreach (q[i]) if ((q[i].addr >> 2) == (ld_addr >> 2)) hit = 1'b1;
            hit   = hit && ld_valid;
            ld_go = ld_valid && !hit && !flush_req;
            st_go = (n > 0) && !ld_go;
            chk("count", 32'(count), 32'(n));
            chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
            chk("ld_stall", 32'(ld_stall), 32'(hit || (flush_req && ld_valid)));
            chk("mem_read", 32'(mem_read), 32'(ld_go));
            chk("mem_write", 32'(mem_write), 32'(st_go));
            chk("flush_done", 32'(flush_done), 32'(flush_req && n == 0));
            if (ld_go) begin
                chk("ld_addr", mem_addr, ld_addr);
                chk("ld_mode", mem_mode, 32'(ld_mode));
            end
            if (st_go) begin
                chk("wr_addr", mem_addr, q[0].addr);
                chk("wr_data", mem_data, q[0].data);
                chk("wr_pc", mem_pc, q[0].pc);
                chk("wr_mode", mem_mode, 32'(q[0].mode));
                void'(q.pop_front());
            end
            if (mem_write) wlog.push_back(mem_addr);
            if (st_valid && n < DEPTH) begin
                e.mode = st_mode; e.addr = st_addr; e.data = st_data; e.pc = st_pc;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        st_valid = 1'b0; ld_valid = 1'b0; flush_req = 1'b0;
    endtask

    task automatic put_st(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        st_valid = 1'b1; st_mode = m; st_addr = a; st_data = d; st_pc = p;
    endtask

    task automatic put_ld(input logic [1:0] m, input logic [31:0] a);
        ld_valid = 1'b1; ld_mode = m; ld_addr = a;
    endtask

    // Holds the current load and counts stalled cycles until it is granted.
    task automatic count_stall(output int stalls);
        bit done;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!ld_stall) done = 1'b1;
            else stalls++;
        end
        chk("stall_bounded", 32'(done), 1);
    endtask

    function automatic logic [31:0] rnd_addr(input logic [1:0] m);
        logic [31:0] base;
        base = 32'($urandom_range(0, 15)) << 2;
        case (m)
            2'd1:    return base | 32'($urandom_range(0, 3));
            2'd2:    return base | (32'($urandom_range(0, 1)) << 1);
            default: return base;
        endcase
    endfunction

    initial begin
        int stalls;
        reset = 1'b0;
        idle_in();
        st_mode = 2'd0; st_addr = '0; st_data = '0; st_pc = '0;
        ld_mode = 2'd0; ld_addr = '0;
        repeat (3) tick();
        reset = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk("idle_count", 32'(count), 0);
            chk("idle_st_ready", 32'(st_ready), 1);
            chk("idle_mem_write", 32'(mem_write), 0);
        end

        tick();
        put_st(2'd0, 32'h10, 32'h1234ABCD, 32'h3000);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("single_write", 32'(mem_write), 1);
        chk("single_addr", mem_addr, 32'h10);
        chk("single_data", mem_data, 32'h1234ABCD);
        chk("single_mode", mem_mode, 32'h0);
        chk("single_pc", mem_pc, 32'h3000);
        tick();
        @(negedge clk);
        chk("single_empty", 32'(count), 0);

        tick();
        put_ld(2'd0, 32'h100);
        for (int k = 0; k < 4; k++) begin
            put_st(2'd0, 32'h200 + 32'(4 * k), 32'(k), 32'h4000 + 32'(4 * k));
            @(negedge clk);
            chk("fill_mem_read", 32'(mem_read), 1);
            tick();
        end
        put_st(2'd0, 32'h210, 32'h5, 32'h4010);
        @(negedge clk);
        chk("full_count", 32'(count), 4);
        chk("full_st_ready", 32'(st_ready), 0);
        chk("full_mem_read", 32'(mem_read), 1);
        chk("full_no_write", 32'(mem_write), 0);
        tick();
        @(negedge clk);
        chk("fifth_blocked", 32'(count), 4);
        tick();
        idle_in();
        wlog.delete();
        repeat (4) tick();
        chk("drain_n", 32'(wlog.size()), 4);
        for (int k = 0; k < 4; k++) chk("drain_order", log_at(k), 32'h200 + 32'(4 * k));
        @(negedge clk);
        chk("drain_empty", 32'(count), 0);

        tick();
        wlog.delete();
        put_st(2'd1, 32'h21, 32'hEE, 32'h5000);
        tick();
        st_valid = 1'b0;
        put_ld(2'd0, 32'h20);
        count_stall(stalls);
        chk("byte_stall_len", 32'(stalls), 1);
        chk("byte_load_read", 32'(mem_read), 1);
        chk("byte_load_addr", mem_addr, 32'h20);
        chk("byte_write", log_at(0), 32'h21);
        tick();
        idle_in();

        tick();
        put_ld(2'd0, 32'h100);
        put_st(2'd0, 32'h40, 32'hA, 32'h6000); tick();
        put_st(2'd0, 32'h80, 32'hB, 32'h6004); tick();
        put_st(2'd0, 32'h44, 32'hC, 32'h6008); tick();
        st_valid = 1'b0;
        wlog.delete();
        put_ld(2'd0, 32'h44);
        count_stall(stalls);
        chk("chain_stall_len", 32'(stalls), 3);
        chk("chain_w0", log_at(0), 32'h40);
        chk("chain_w1", log_at(1), 32'h80);
        chk("chain_w2", log_at(2), 32'h44);
        chk("chain_load_addr", mem_addr, 32'h44);
        tick();
        idle_in();

        tick();
        put_ld(2'd0, 32'h100);
        put_st(2'd0, 32'h300, 32'h1, 32'h7000); tick();
        put_st(2'd0, 32'h304, 32'h2, 32'h7004); tick();
        put_st(2'd0, 32'h308, 32'h3, 32'h7008); tick();
        st_valid = 1'b0;
        flush_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("flush_write", 32'(mem_write), 1);
            chk("flush_stall", 32'(ld_stall), 1);
            chk("flush_not_done", 32'(flush_done), 0);
        end
        @(negedge clk);
        chk("flush_done", 32'(flush_done), 1);
        chk("flush_done_stall", 32'(ld_stall), 1);
        chk("flush_done_idle", 32'(mem_write), 0);
        tick();
        idle_in();

        tick();
        put_ld(2'd0, 32'h100);
        put_st(2'd0, 32'h400, 32'h1, 32'h8000); tick();
        put_st(2'd0, 32'h404, 32'h2, 32'h8004); tick();
        put_st(2'd0, 32'h408, 32'h3, 32'h8008); tick();
        idle_in();
        wlog.delete();
        #3 reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_write", 32'(mem_write), 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_no_writes", 32'(wlog.size()), 0);
        chk("rst_count_after", 32'(count), 0);

        for (int c = 0; c < 3000; c++) begin
            st_valid  = ($urandom_range(0, 1) == 1);
            st_mode   = 2'($urandom_range(0, 2));
            st_addr   = rnd_addr(st_mode);
            st_data   = $urandom;
            st_pc     = $urandom;
            ld_valid  = ($urandom_range(0, 1) == 1);
            ld_mode   = 2'($urandom_range(0, 2));
            ld_addr   = rnd_addr(ld_mode);
            flush_req = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_in();
        repeat (8) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
